// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word fetches and
// buffers returned words with their PCs in a small FIFO; a redirect flushes everything.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [31:0]   data_r [DEPTH];
  logic [31:0]   pc_r   [DEPTH];

  logic          credit_s;
  logic          req_fire_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [31:0]   target_s;
  logic [CW:0]   inflight_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW-1:0] drop_nxt_s;
  logic [CW-1:0] count_nxt_s;

  assign imem_req_addr = fetch_pc_r;
  assign instruction   = data_r[rd_ptr_r];
  assign inst_pc       = pc_r[rd_ptr_r];

  // Handshake qualification and next-state arithmetic for the counters
  always_comb begin
    inflight_s     = {1'b0, outstanding_r} + {1'b0, count_r};
    credit_s       = (inflight_s < (CW+1)'(DEPTH));
    imem_req_valid = credit_s && !redirect_valid && !rst;
    req_fire_s     = imem_req_valid && imem_req_ready;
    inst_valid     = (count_r != {CW{1'b0}});
    drop_s         = imem_rsp_valid && (drop_cnt_r != {CW{1'b0}});
    push_s         = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !redirect_valid;
    pop_s          = inst_valid && inst_ready && !redirect_valid;
    target_s       = redirect_pc & 32'hFFFF_FFFC;
    outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
    // Every word still in flight at a redirect is stale, except one retiring right now
    if (redirect_valid) begin
      drop_nxt_s = outstanding_r - CW'(imem_rsp_valid);
    end else if (drop_s) begin
      drop_nxt_s = drop_cnt_r - CW'(1);
    end else begin
      drop_nxt_s = drop_cnt_r;
    end
    if (redirect_valid) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // PCs, counters and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      count_r       <= {CW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
    end else begin
      outstanding_r <= outstanding_nxt_s;
      drop_cnt_r    <= drop_nxt_s;
      count_r       <= count_nxt_s;
      if (redirect_valid) begin
        fetch_pc_r <= target_s;
        rsp_pc_r   <= target_s;
        rd_ptr_r   <= {AW{1'b0}};
        wr_ptr_r   <= {AW{1'b0}};
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (push_s) begin
          rsp_pc_r <= rsp_pc_r + 32'd4;
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
      end
    end
  end

  // FIFO storage: instruction word paired with the PC it was fetched from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= 32'h0000_0000;
        pc_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_r[wr_ptr_r] <= imem_rsp_data;
      pc_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end

  fetch_unit_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .count       (count_r),
    .outstanding (outstanding_r),
    .drop_cnt    (drop_cnt_r)
  );
endmodule

// Invariant checker: the credit scheme must never overflow the FIFO or over-drop.
module fetch_unit_chk #(
  parameter int CW    = 2,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] drop_cnt
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH))));
  a_drop_bound:  assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, randomized traffic against a
// queue-based reference model, and a second instance exercising PC wrap and async reset.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] instruction, inst_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;

  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_inst_valid, w_inst_ready;
  logic [31:0] w_instruction, w_inst_pc;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .instruction(w_instruction), .inst_pc(w_inst_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000)
  );

  typedef struct {
    logic rdy; logic rv; logic [31:0] rd; logic ird; logic redir; logic [31:0] rpc;
    logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_ins; logic [31:0] e_pc;
  } vec_t;
  typedef struct { logic [31:0] addr; bit keep; int due; } fl_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

  vec_t        tbl[$];
  fl_t         inflight[$];
  ent_t        mfifo[$];
  logic [31:0] m_fetch;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0; inst_ready = 1'b0;
    redir_valid = 1'b0; redir_pc = 32'h0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0; w_inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inflight.delete();
    mfifo.delete();
    m_fetch = 32'h0000_0000;
    cyc = 0;
  endtask

  // One cycle of memory + downstream traffic, checked against the abstract model.
  task automatic run_cycle(input int lat_min, input int lat_max, input int rdy_pct,
                           input int ird_pct, input int redir_pm);
    bit   exp_rv, exp_iv;
    fl_t  f;
    @(negedge clk);
    req_ready   = ($urandom_range(99) < rdy_pct);
    inst_ready  = ($urandom_range(99) < ird_pct);
    redir_valid = ($urandom_range(999) < redir_pm);
    redir_pc    = $urandom();
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = inflight[0].addr ^ 32'hA5A5_0000;
    end
    #1;
    exp_rv = ((inflight.size() + mfifo.size()) < DEPTH) && !redir_valid;
    exp_iv = (mfifo.size() != 0);
    chk("rnd_req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
    chk("rnd_req_addr", req_addr, m_fetch);
    chk("rnd_inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      chk("rnd_instruction", instruction, mfifo[0].data);
      chk("rnd_inst_pc", inst_pc, mfifo[0].pc);
    end
    if (redir_valid) begin
      mfifo.delete();
      foreach (inflight[i]) inflight[i].keep = 1'b0;
    end else if (exp_iv && inst_ready) begin
      void'(mfifo.pop_front());
    end
    if (rsp_valid) begin
      f = inflight.pop_front();
      if (f.keep) mfifo.push_back('{rsp_data, f.addr});
    end
    if (exp_rv && req_ready) begin
      inflight.push_back('{m_fetch, 1'b1, cyc + $urandom_range(lat_max, lat_min)});
      m_fetch = m_fetch + 32'd4;
    end
    if (redir_valid) m_fetch = redir_pc & 32'hFFFF_FFFC;
    cyc++;
  endtask

  initial begin
    bit          p;
    logic [31:0] pa, ep;
    int          k;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_req_addr", req_addr, 32'h0000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
    chk("rst_wrap_valid", {31'b0, w_req_valid}, 32'h0);
    rst = 1'b0;

    // rdy rv rd ird redir rpc | exp: req_valid req_addr inst_valid instruction inst_pc
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_0000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_0004,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b1,32'h1002,  1'b0,32'h0000_0008,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b1,32'hA5A50000, 1'b0,1'b0,32'h0,     1'b0,32'h0000_1000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b1,32'hA5A50004, 1'b0,1'b0,32'h0,     1'b1,32'h0000_1000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_1004,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b1,32'h11110000, 1'b0,1'b0,32'h0,     1'b0,32'h0000_1008,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b1,32'h22220000, 1'b0,1'b0,32'h0,     1'b0,32'h0000_1008,1'b1,32'h11110000,32'h1000});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b0,32'h0000_1008,1'b1,32'h11110000,32'h1000});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,     1'b0,32'h0000_1008,1'b1,32'h11110000,32'h1000});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_1008,1'b1,32'h22220000,32'h1004});
    tbl.push_back('{1'b0,1'b1,32'h33330000, 1'b1,1'b1,32'h2000,  1'b0,32'h0000_100C,1'b1,32'h22220000,32'h1004});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_2000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_2000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b1,32'h44440000, 1'b0,1'b0,32'h0,     1'b1,32'h0000_2004,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,     1'b1,32'h0000_2004,1'b1,32'h44440000,32'h2000});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_2004,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_2008,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b1,32'h55550000, 1'b0,1'b1,32'h3000,  1'b0,32'h0000_200C,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h4001,  1'b0,32'h0000_3000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b1,32'h66660000, 1'b0,1'b0,32'h0,     1'b1,32'h0000_4000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_4000,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b1,32'h77770000, 1'b0,1'b0,32'h0,     1'b1,32'h0000_4004,1'b0,32'h0,32'h0});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,     1'b1,32'h0000_4004,1'b1,32'h77770000,32'h4000});
    tbl.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,     1'b1,32'h0000_4004,1'b0,32'h0,32'h0});

    foreach (tbl[i]) begin
      @(negedge clk);
      req_ready = tbl[i].rdy; rsp_valid = tbl[i].rv; rsp_data = tbl[i].rd;
      inst_ready = tbl[i].ird; redir_valid = tbl[i].redir; redir_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, req_valid}, {31'b0, tbl[i].e_rv});
      chk($sformatf("tbl%0d_req_addr", i), req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].e_iv) begin
        chk($sformatf("tbl%0d_instruction", i), instruction, tbl[i].e_ins);
        chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
      end
    end

    // Randomized phases: steady stream, downstream stall, random latency/ready/redirects.
    do_reset();
    for (int i = 0; i < 30; i++)  run_cycle(1, 1, 100, 100, 0);
    for (int i = 0; i < 10; i++)  run_cycle(1, 1, 100, 0, 0);
    for (int i = 0; i < 20; i++)  run_cycle(1, 1, 100, 100, 0);
    for (int i = 0; i < 600; i++) run_cycle(1, 3, 60, 70, 0);
    for (int i = 0; i < 800; i++) run_cycle(1, 3, 60, 60, 40);

    // Wrap instance: RESET_PC near the top of the address space, 1-cycle memory.
    do_reset();
    p = 1'b0; pa = 32'h0; k = 0; ep = 32'hFFFF_FFF8;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      w_req_ready = 1'b1; w_inst_ready = 1'b1;
      w_rsp_valid = p; w_rsp_data = pa ^ 32'hA5A5_0000;
      #1;
      if (w_inst_valid) begin
        chk("wrap_inst_pc", w_inst_pc, ep);
        chk("wrap_instruction", w_instruction, ep ^ 32'hA5A5_0000);
        ep = ep + 32'd4;
        k++;
      end
      p = w_req_valid && w_req_ready;
      pa = w_req_addr;
    end
    chk("wrap_delivered_ge4", {31'b0, (k >= 4)}, 32'h1);

    // Stall downstream until the head is valid, then assert reset between clock edges.
    k = 0;
    for (int c = 0; c < 8 && k == 0; c++) begin
      @(negedge clk);
      w_inst_ready = 1'b0;
      w_rsp_valid = p; w_rsp_data = pa ^ 32'hA5A5_0000;
      #1;
      p = w_req_valid && w_req_ready;
      pa = w_req_addr;
      if (w_inst_valid) k = 1;
    end
    chk("pre_rst_inst_valid", {31'b0, w_inst_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_inst_valid", {31'b0, w_inst_valid}, 32'h0);
    chk("async_rst_req_valid", {31'b0, w_req_valid}, 32'h0);
    chk("async_rst_req_addr", w_req_addr, 32'hFFFF_FFF8);
    w_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
